// File: rtl/sweep_learn_ctrl.sv
//==============================================================================
// Module   : sweep_learn_ctrl
// Purpose  : Learn-sweep sequencer: steps the DDS, settles, measures ADC
//            peak-to-peak per point and writes it to the amplitude table.
//            Optional peak tracking under `SWEEP_PEAK_TRACK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sweep_learn_ctrl #(
    parameter int N_POINTS     = 100,
    parameter int SETTLE_CYC   = 50000,
    parameter int MEAS_SAMPLES = 1024,
    parameter int NEXT_PW      = 4,
    parameter int ADC_W        = 10,
    parameter int IDX_W        = 7
) (
    input  logic             clk_50m,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [ADC_W-1:0] adc_data,
    input  logic             adc_valid,
    output logic             learn_en,
    output logic             next_freq,
    output logic             amp_wr_en,
    output logic [IDX_W-1:0] amp_wr_addr,
    output logic [ADC_W-1:0] amp_wr_data,
    output logic             busy,
    output logic             done,
    output logic [ADC_W-1:0] peak_amp,
    output logic [IDX_W-1:0] peak_idx
);

    localparam int SET_W = (SETTLE_CYC   > 1) ? $clog2(SETTLE_CYC)   : 1;
    localparam int SMP_W = (MEAS_SAMPLES > 1) ? $clog2(MEAS_SAMPLES) : 1;
    localparam int STP_W = (NEXT_PW      > 1) ? $clog2(NEXT_PW)      : 1;

    localparam logic [SET_W-1:0] c_SET_LAST = SET_W'(SETTLE_CYC - 1);
    localparam logic [SMP_W-1:0] c_SMP_LAST = SMP_W'(MEAS_SAMPLES - 1);
    localparam logic [STP_W-1:0] c_STP_LAST = STP_W'(NEXT_PW - 1);
    localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(N_POINTS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_MEASURE = 3'd2,
        S_WRITE   = 3'd3,
        S_STEP    = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t           r_state;
    logic [SET_W-1:0] r_settle_cnt;
    logic [SMP_W-1:0] r_samp_cnt;
    logic [STP_W-1:0] r_step_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [ADC_W-1:0] r_min;
    logic [ADC_W-1:0] r_max;

    logic             r_learn_en;
    logic             r_next_freq;
    logic             r_amp_wr_en;
    logic [IDX_W-1:0] r_amp_wr_addr;
    logic [ADC_W-1:0] r_amp_wr_data;
    logic             r_busy;
    logic             r_done;

    logic [ADC_W-1:0] w_min;
    logic [ADC_W-1:0] w_max;
    logic [ADC_W-1:0] w_amp;
    logic             w_start_go;
    logic             w_write_go;

    // Running extrema including the sample on the bus this cycle, so the last
    // window sample lands in the written amplitude without an extra cycle.
    assign w_min      = (adc_data < r_min) ? adc_data : r_min;
    assign w_max      = (adc_data > r_max) ? adc_data : r_max;
    assign w_amp      = w_max - w_min;
    assign w_start_go = (r_state == S_IDLE) && start && !abort;
    assign w_write_go = (r_state == S_MEASURE) && adc_valid && !abort &&
                        (r_samp_cnt == c_SMP_LAST);

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_settle_cnt  <= '0;
            r_samp_cnt    <= '0;
            r_step_cnt    <= '0;
            r_idx         <= '0;
            r_min         <= '0;
            r_max         <= '0;
            r_learn_en    <= 1'b0;
            r_next_freq   <= 1'b0;
            r_amp_wr_en   <= 1'b0;
            r_amp_wr_addr <= '0;
            r_amp_wr_data <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_amp_wr_en <= 1'b0;
            r_done      <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state     <= S_IDLE;
                r_learn_en  <= 1'b0;
                r_next_freq <= 1'b0;
                r_busy      <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_go) begin
                            r_state      <= S_SETTLE;
                            r_learn_en   <= 1'b1;
                            r_busy       <= 1'b1;
                            r_idx        <= '0;
                            r_settle_cnt <= '0;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == c_SET_LAST) begin
                            r_state    <= S_MEASURE;
                            r_min      <= '1;
                            r_max      <= '0;
                            r_samp_cnt <= '0;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + SET_W'(1);
                        end
                    end
                    S_MEASURE: begin
                        if (adc_valid) begin
                            r_min <= w_min;
                            r_max <= w_max;
                            if (w_write_go) begin
                                r_state       <= S_WRITE;
                                r_amp_wr_en   <= 1'b1;
                                r_amp_wr_addr <= r_idx;
                                r_amp_wr_data <= w_amp;
                            end else begin
                                r_samp_cnt <= r_samp_cnt + SMP_W'(1);
                            end
                        end
                    end
                    S_WRITE: begin
                        if (r_idx == c_IDX_LAST) begin
                            r_state    <= S_FINISH;
                            r_done     <= 1'b1;
                            r_learn_en <= 1'b0;
                        end else begin
                            r_state     <= S_STEP;
                            r_next_freq <= 1'b1;
                            r_step_cnt  <= '0;
                        end
                    end
                    S_STEP: begin
                        if (r_step_cnt == c_STP_LAST) begin
                            r_state      <= S_SETTLE;
                            r_next_freq  <= 1'b0;
                            r_idx        <= r_idx + IDX_W'(1);
                            r_settle_cnt <= '0;
                        end else begin
                            r_step_cnt <= r_step_cnt + STP_W'(1);
                        end
                    end
                    S_FINISH: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign learn_en    = r_learn_en;
    assign next_freq   = r_next_freq;
    assign amp_wr_en   = r_amp_wr_en;
    assign amp_wr_addr = r_amp_wr_addr;
    assign amp_wr_data = r_amp_wr_data;
    assign busy        = r_busy;
    assign done        = r_done;

`ifdef SWEEP_PEAK_TRACK_EN
    logic [ADC_W-1:0] r_peak_amp;
    logic [IDX_W-1:0] r_peak_idx;

    // Strictly-greater update keeps the earliest index on ties.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_peak_amp <= '0;
            r_peak_idx <= '0;
        end else if (w_start_go) begin
            r_peak_amp <= '0;
            r_peak_idx <= '0;
        end else if (w_write_go && (w_amp > r_peak_amp)) begin
            r_peak_amp <= w_amp;
            r_peak_idx <= r_idx;
        end
    end

    assign peak_amp = r_peak_amp;
    assign peak_idx = r_peak_idx;
`else
    assign peak_amp = '0;
    assign peak_idx = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sweep_learn_ctrl.sv
//==============================================================================
// Module   : tb_sweep_learn_ctrl
// Purpose  : Scoreboard bench for sweep_learn_ctrl; optional peak checks follow
//            `SWEEP_PEAK_TRACK_EN.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sweep_learn_ctrl;

    localparam int N_POINTS     = 3;
    localparam int SETTLE_CYC   = 8;
    localparam int MEAS_SAMPLES = 4;
    localparam int NEXT_PW      = 3;
    localparam int ADC_W        = 10;
    localparam int IDX_W        = 7;

    logic             clk_50m   = 1'b0;
    logic             rst_n     = 1'b0;
    logic             start     = 1'b0;
    logic             abort     = 1'b0;
    logic [ADC_W-1:0] adc_data  = '0;
    logic             adc_valid = 1'b0;
    logic             learn_en;
    logic             next_freq;
    logic             amp_wr_en;
    logic [IDX_W-1:0] amp_wr_addr;
    logic [ADC_W-1:0] amp_wr_data;
    logic             busy;
    logic             done;
    logic [ADC_W-1:0] peak_amp;
    logic [IDX_W-1:0] peak_idx;

    sweep_learn_ctrl #(
        .N_POINTS    (N_POINTS),
        .SETTLE_CYC  (SETTLE_CYC),
        .MEAS_SAMPLES(MEAS_SAMPLES),
        .NEXT_PW     (NEXT_PW),
        .ADC_W       (ADC_W),
        .IDX_W       (IDX_W)
    ) u_dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .adc_data   (adc_data),
        .adc_valid  (adc_valid),
        .learn_en   (learn_en),
        .next_freq  (next_freq),
        .amp_wr_en  (amp_wr_en),
        .amp_wr_addr(amp_wr_addr),
        .amp_wr_data(amp_wr_data),
        .busy       (busy),
        .done       (done),
        .peak_amp   (peak_amp),
        .peak_idx   (peak_idx)
    );

    always #5 clk_50m = ~clk_50m;

    int cyc = 0;
    always @(posedge clk_50m) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int at;
    } wr_t;

    wr_t  wr_q[$];
    int   done_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_on = 1'b0;
    logic exp_learn = 1'b0;
    logic exp_busy  = 1'b0;
    logic exp_nf    = 1'b0;
    int   pk_amp = 0;
    int   pk_idx = 0;
    int   valid_mode = 0;
    int   directed = 0;
    int   dir_samp[N_POINTS][MEAS_SAMPLES];

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    task automatic drive_junk();
        adc_valid = 1'($urandom_range(0, 1));
        adc_data  = ADC_W'($urandom_range(0, 1023));
    endtask

    task automatic check_peak(input string tag);
`ifdef SWEEP_PEAK_TRACK_EN
        chk({tag, "_peak_amp"}, int'(peak_amp), pk_amp);
        chk({tag, "_peak_idx"}, int'(peak_idx), pk_idx);
`else
        chk({tag, "_peak_amp"}, int'(peak_amp), 0);
        chk({tag, "_peak_idx"}, int'(peak_idx), 0);
`endif
    endtask

    // Monitor: per-cycle level checks plus scoreboard pops on write / done.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk_50m);
            if (mon_on) begin
                chk("learn_en", int'(learn_en), int'(exp_learn));
                chk("busy", int'(busy), int'(exp_busy));
                chk("next_freq", int'(next_freq), int'(exp_nf));
                if (amp_wr_en) begin
                    if (wr_q.size() == 0) begin
                        chk("unexpected_write", int'(amp_wr_en), 0);
                    end else begin
                        e = wr_q.pop_front();
                        chk("wr_addr", int'(amp_wr_addr), e.addr);
                        chk("wr_data", int'(amp_wr_data), e.data);
                        chk("wr_cycle", cyc, e.at);
                    end
                end
                if (done) begin
                    if (done_q.size() == 0) chk("unexpected_done", int'(done), 0);
                    else chk("done_cycle", cyc, done_q.pop_front());
                end
            end
        end
    end

    // One learn sweep from the spec's timing rules. Interruption (kind 1 =
    // abort, 2 = reset) happens with the third valid sample of point intr_pt.
    task automatic sweep(input int intr_pt, input int kind, input int restart_pt);
        int mn, mx, nv, m, amp, d;
        logic v;
        start = 1'b1;
        drive_junk();
        tick();
        start     = 1'b0;
        exp_learn = 1'b1;
        exp_busy  = 1'b1;
        pk_amp    = 0;
        pk_idx    = 0;
        for (int k = 0; k < N_POINTS; k++) begin
            for (int s = 0; s < SETTLE_CYC; s++) begin
                drive_junk();
                if (k == restart_pt && s == 3) start = 1'b1;
                tick();
                start = 1'b0;
            end
            mn = 1023; mx = 0; nv = 0; m = 0;
            while (nv < MEAS_SAMPLES) begin
                case (valid_mode)
                    0:       v = 1'b1;
                    1:       v = ((m % 3) == 2);
                    default: v = 1'($urandom_range(0, 1));
                endcase
                if (v && directed != 0) d = dir_samp[k][nv];
                else d = int'($urandom_range(0, 1023));
                adc_valid = v;
                adc_data  = ADC_W'(d);
                if (k == intr_pt && nv == 2 && v) begin
                    if (kind == 1) abort = 1'b1;
                    else rst_n = 1'b0;
                    tick();
                    abort     = 1'b0;
                    rst_n     = 1'b1;
                    adc_valid = 1'b0;
                    exp_learn = 1'b0;
                    exp_busy  = 1'b0;
                    exp_nf    = 1'b0;
                    if (kind == 2) begin
                        pk_amp = 0;
                        pk_idx = 0;
                    end
                    return;
                end
                tick();
                m++;
                if (v) begin
                    nv++;
                    if (d < mn) mn = d;
                    if (d > mx) mx = d;
                end
            end
            amp = mx - mn;
            wr_q.push_back('{k, amp, cyc});
            if (amp > pk_amp) begin
                pk_amp = amp;
                pk_idx = k;
            end
            if (k == N_POINTS - 1) begin
                done_q.push_back(cyc + 1);
                drive_junk();
                tick();
                exp_learn = 1'b0;
                drive_junk();
                tick();
                exp_busy  = 1'b0;
                adc_valid = 1'b0;
                return;
            end
            drive_junk();
            tick();
            exp_nf = 1'b1;
            repeat (NEXT_PW) begin
                drive_junk();
                tick();
            end
            exp_nf = 1'b0;
        end
    endtask

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        dir_samp = '{'{100, 400, 250, 300}, '{0, 500, 200, 100}, '{10, 510, 300, 200}};
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_learn_en", int'(learn_en), 0);
        chk("rst_next_freq", int'(next_freq), 0);
        chk("rst_amp_wr_en", int'(amp_wr_en), 0);
        chk("rst_amp_wr_addr", int'(amp_wr_addr), 0);
        chk("rst_amp_wr_data", int'(amp_wr_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_peak_amp", int'(peak_amp), 0);
        chk("rst_peak_idx", int'(peak_idx), 0);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        repeat (2) tick();

        // Directed amplitudes 300, 500, 500 with continuous valid.
        directed = 1; valid_mode = 0;
        sweep(-1, 0, -1);
        repeat (3) tick();
        check_peak("directed");

        // Sparse valid (1 in 3) with a start re-pulse during point 1.
        directed = 0; valid_mode = 1;
        sweep(-1, 0, 1);
        repeat (2) tick();
        check_peak("sparse");

        // Abort during point 1 measurement.
        valid_mode = 2;
        sweep(1, 1, -1);
        repeat (4) tick();
        chk("abort_busy", int'(busy), 0);
        check_peak("abort");

        // start and abort together while idle.
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        repeat (4) tick();
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_learn", int'(learn_en), 0);

        // Reset mid-measurement of point 0.
        valid_mode = 0;
        sweep(0, 2, -1);
        repeat (3) tick();
        check_peak("reset");

        for (int i = 0; i < 4; i++) begin
            valid_mode = 2;
            sweep(-1, 0, -1);
            repeat (2) tick();
            check_peak("random");
        end

        repeat (3) tick();
        chk("wr_q_left", wr_q.size(), 0);
        chk("done_q_left", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
